framebuffer_writer: RTL and testbench

FRAMEBUFFER_WRITER -- requirements
Module: framebuffer_writer

---
 rtl/fb_pkg.sv | 14 +
 rtl/fb_addr_gen.sv | 30 +++
 rtl/framebuffer_writer.sv | 169 ++++++++++++++++
 tb/tb_framebuffer_writer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared resolution constants and FSM state encoding for the framebuffer writer.
package fb_pkg;

    localparam int H_RES   = 800;
    localparam int V_RES   = 600;
    localparam int FB_SIZE = H_RES * V_RES;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } fb_state_e;

endpackage

// File: rtl/fb_addr_gen.sv
// Combinational framebuffer address: base + y*H_RES + x, using a constant shift-add
// multiply and truncated to ADDR_W bits.
module fb_addr_gen
    import fb_pkg::*;
#(
    parameter int H_RES  = fb_pkg::H_RES,
    parameter int ADDR_W = 20
) (
    input  logic [10:0]       x,
    input  logic [10:0]       y,
    input  logic [ADDR_W-1:0] base,
    output logic [ADDR_W-1:0] addr
);

    localparam logic [11:0] H_BITS = 12'(H_RES);

    logic [ADDR_W-1:0] row_off;

    // One shifted copy of y per set bit of the constant line width.
    always_comb begin
        row_off = '0;
        for (int i = 0; i < 12; i++) begin
            if (H_BITS[i]) begin
                row_off = row_off + (ADDR_W'(y) << i);
            end
        end
        addr = row_off + ADDR_W'(x) + base;
    end

endmodule

// File: rtl/framebuffer_writer.sv
// Two-stage pixel-to-framebuffer writer with stall handling, range dropping and end-of-frame
// handshake. Define FB_DOUBLE_BUFFER_EN to alternate between two framebuffer halves.
module framebuffer_writer
    import fb_pkg::*;
#(
    parameter int H_RES  = fb_pkg::H_RES,
    parameter int V_RES  = fb_pkg::V_RES,
    parameter int ADDR_W = 20
) (
    input  logic              clk,
    input  logic              aresetn,
    input  logic [7:0]        pix_data,
    input  logic [10:0]       pix_x,
    input  logic [10:0]       pix_y,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic              frame_end,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    input  logic              mem_busy,
    output logic              frame_done,
    output logic              disp_buf,
    output logic [15:0]       drop_count
);

    localparam logic [11:0] H_LIM = 12'(H_RES);
    localparam logic [11:0] V_LIM = 12'(V_RES);

    fb_state_e         state_q, state_d;
    logic              fe_q, fe_d;
    logic              s1_valid_q, s1_valid_d;
    logic [10:0]       s1_x_q, s1_x_d;
    logic [10:0]       s1_y_q, s1_y_d;
    logic [7:0]        s1_data_q, s1_data_d;
    logic              s1_in_range_q, s1_in_range_d;
    logic              s2_valid_q, s2_valid_d;
    logic              s2_wr_q, s2_wr_d;
    logic [ADDR_W-1:0] s2_addr_q, s2_addr_d;
    logic [7:0]        s2_data_q, s2_data_d;
    logic [15:0]       drop_count_q, drop_count_d;

    logic              stall;
    logic              accept;
    logic              in_range;
    logic              fe_edge;
    logic              pipe_empty;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] gen_addr;

`ifdef FB_DOUBLE_BUFFER_EN
    localparam logic [ADDR_W-1:0] BACK_BASE = ADDR_W'(H_RES * V_RES);

    logic disp_buf_q, disp_buf_d;

    // Render into the half that is not being displayed.
    assign base       = disp_buf_q ? '0 : BACK_BASE;
    assign disp_buf   = disp_buf_q;
    assign disp_buf_d = (state_q == ST_DONE) ? ~disp_buf_q : disp_buf_q;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            disp_buf_q <= 1'b0;
        end else begin
            disp_buf_q <= disp_buf_d;
        end
    end
`else
    assign base     = '0;
    assign disp_buf = 1'b0;
`endif

    fb_addr_gen #(
        .H_RES  (H_RES),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .x    (s1_x_q),
        .y    (s1_y_q),
        .base (base),
        .addr (gen_addr)
    );

    assign stall      = s2_valid_q && mem_busy;
    assign pix_ready  = !stall;
    assign accept     = pix_valid && !stall;
    assign in_range   = ({1'b0, pix_x} < H_LIM) && ({1'b0, pix_y} < V_LIM);
    assign fe_edge    = frame_end && !fe_q;
    // S2 counts as empty when it is retiring this cycle, so done follows the last write directly.
    assign pipe_empty = !s1_valid_q && !stall && !accept;

    assign mem_we     = s2_valid_q && s2_wr_q && !mem_busy;
    assign mem_addr   = s2_addr_q;
    assign mem_wdata  = s2_data_q;
    assign frame_done = (state_q == ST_DONE);
    assign drop_count = drop_count_q;

    always_comb begin
        state_d       = state_q;
        fe_d          = frame_end;
        s1_valid_d    = s1_valid_q;
        s1_x_d        = s1_x_q;
        s1_y_d        = s1_y_q;
        s1_data_d     = s1_data_q;
        s1_in_range_d = s1_in_range_q;
        s2_valid_d    = s2_valid_q;
        s2_wr_d       = s2_wr_q;
        s2_addr_d     = s2_addr_q;
        s2_data_d     = s2_data_q;
        drop_count_d  = drop_count_q;

        if (!stall) begin
            s1_valid_d = accept;
            if (accept) begin
                s1_x_d        = pix_x;
                s1_y_d        = pix_y;
                s1_data_d     = pix_data;
                s1_in_range_d = in_range;
            end
            s2_valid_d = s1_valid_q;
            s2_wr_d    = s1_valid_q && s1_in_range_q && (s1_data_q != 8'h00);
            if (s1_valid_q) begin
                s2_addr_d = gen_addr;
                s2_data_d = s1_data_q;
            end
        end

        if (accept && !in_range && (drop_count_q != 16'hFFFF)) begin
            drop_count_d = drop_count_q + 16'd1;
        end

        case (state_q)
            ST_RUN:   if (fe_edge) state_d = ST_DRAIN;
            ST_DRAIN: if (pipe_empty) state_d = ST_DONE;
            ST_DONE:  state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q       <= ST_RUN;
            fe_q          <= 1'b1;
            s1_valid_q    <= 1'b0;
            s1_x_q        <= '0;
            s1_y_q        <= '0;
            s1_data_q     <= '0;
            s1_in_range_q <= 1'b0;
            s2_valid_q    <= 1'b0;
            s2_wr_q       <= 1'b0;
            s2_addr_q     <= '0;
            s2_data_q     <= '0;
            drop_count_q  <= '0;
        end else begin
            state_q       <= state_d;
            fe_q          <= fe_d;
            s1_valid_q    <= s1_valid_d;
            s1_x_q        <= s1_x_d;
            s1_y_q        <= s1_y_d;
            s1_data_q     <= s1_data_d;
            s1_in_range_q <= s1_in_range_d;
            s2_valid_q    <= s2_valid_d;
            s2_wr_q       <= s2_wr_d;
            s2_addr_q     <= s2_addr_d;
            s2_data_q     <= s2_data_d;
            drop_count_q  <= drop_count_d;
        end
    end

endmodule

// File: tb/tb_framebuffer_writer.sv
// Directed self-checking bench for framebuffer_writer: inputs change and outputs are
// sampled just after each falling clock edge, one task per scenario.
module tb_framebuffer_writer;

`ifdef FB_DOUBLE_BUFFER_EN
    localparam int BACK_WORDS = 800 * 600;
`else
    localparam int BACK_WORDS = 0;
`endif

    logic        clk = 1'b0;
    logic        aresetn;
    logic [7:0]  pix_data;
    logic [10:0] pix_x;
    logic [10:0] pix_y;
    logic        pix_valid;
    logic        pix_ready;
    logic        frame_end;
    logic [19:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        mem_busy;
    logic        frame_done;
    logic        disp_buf;
    logic [15:0] drop_count;

    int   n_compared   = 0;
    int   n_mismatched = 0;
    int   exp_base     = BACK_WORDS;
    logic exp_disp     = 1'b0;

    always #5 clk = ~clk;

    framebuffer_writer #(
        .H_RES  (800),
        .V_RES  (600),
        .ADDR_W (20)
    ) dut (
        .clk        (clk),
        .aresetn    (aresetn),
        .pix_data   (pix_data),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .frame_end  (frame_end),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_busy   (mem_busy),
        .frame_done (frame_done),
        .disp_buf   (disp_buf),
        .drop_count (drop_count)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_pix(input logic v, input int x, input int y, input int d);
        pix_valid = v;
        pix_x     = 11'(x);
        pix_y     = 11'(y);
        pix_data  = 8'(d);
    endtask

    // Mirrors the buffer swap that a completed frame causes in the double-buffered build.
    task automatic model_swap();
`ifdef FB_DOUBLE_BUFFER_EN
        exp_disp = ~exp_disp;
        exp_base = exp_disp ? 0 : BACK_WORDS;
`endif
    endtask

    task automatic test_reset();
        aresetn   = 1'b0;
        frame_end = 1'b1;
        mem_busy  = 1'b0;
        set_pix(1'b0, 0, 0, 0);
        tick(); tick(); #1;
        n_compared++; if (pix_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL rst_ready: got %b expected 1", pix_ready); end
        n_compared++; if (mem_we !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rst_we: got %b expected 0", mem_we); end
        n_compared++; if (frame_done !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rst_done: got %b expected 0", frame_done); end
        n_compared++; if (drop_count !== 16'd0) begin n_mismatched++; $display("[TB] FAIL rst_drop: got %0d expected 0", drop_count); end
        n_compared++; if (disp_buf !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rst_disp: got %b expected 0", disp_buf); end
        n_compared++; if (mem_addr !== 20'd0) begin n_mismatched++; $display("[TB] FAIL rst_addr: got %0d expected 0", mem_addr); end
        n_compared++; if (mem_wdata !== 8'd0) begin n_mismatched++; $display("[TB] FAIL rst_wdata: got %h expected 00", mem_wdata); end
        tick();
        aresetn = 1'b1;
        // frame_end held high across release must not count as an edge.
        for (int c = 0; c < 4; c++) begin
            tick(); #1;
            n_compared++; if (frame_done !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rst_level_done c%0d: got %b expected 0", c, frame_done); end
        end
        tick();
        frame_end = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        tick(); set_pix(1'b1, 3, 2, 8'h05); #1;
        n_compared++; if (pix_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL basic_ready: got %b expected 1", pix_ready); end
        tick(); set_pix(1'b0, 0, 0, 0); #1;
        n_compared++; if (mem_we !== 1'b0) begin n_mismatched++; $display("[TB] FAIL basic_we_early: got %b expected 0", mem_we); end
        tick(); #1;
        n_compared++; if (mem_we !== 1'b1) begin n_mismatched++; $display("[TB] FAIL basic_we: got %b expected 1", mem_we); end
        n_compared++; if (mem_addr !== 20'(exp_base + 1603)) begin n_mismatched++; $display("[TB] FAIL basic_addr: got %0d expected %0d", mem_addr, exp_base + 1603); end
        n_compared++; if (mem_wdata !== 8'h05) begin n_mismatched++; $display("[TB] FAIL basic_wdata: got %h expected 05", mem_wdata); end
        tick(); #1;
        n_compared++; if (mem_we !== 1'b0) begin n_mismatched++; $display("[TB] FAIL basic_we_after: got %b expected 0", mem_we); end
    endtask

    task automatic test_range();
        tick(); set_pix(1'b1, 799, 599, 8'h01);
        tick(); set_pix(1'b1, 800, 0, 8'h07);
        tick(); set_pix(1'b0, 0, 0, 0); #1;
        n_compared++; if (mem_we !== 1'b1) begin n_mismatched++; $display("[TB] FAIL range_we_last: got %b expected 1", mem_we); end
        n_compared++; if (mem_addr !== 20'(exp_base + 479999)) begin n_mismatched++; $display("[TB] FAIL range_addr: got %0d expected %0d", mem_addr, exp_base + 479999); end
        n_compared++; if (mem_wdata !== 8'h01) begin n_mismatched++; $display("[TB] FAIL range_wdata: got %h expected 01", mem_wdata); end
        n_compared++; if (drop_count !== 16'd1) begin n_mismatched++; $display("[TB] FAIL range_drop_x: got %0d expected 1", drop_count); end
        tick(); #1;
        n_compared++; if (mem_we !== 1'b0) begin n_mismatched++; $display("[TB] FAIL range_we_dropped_x: got %b expected 0", mem_we); end
        tick(); set_pix(1'b1, 0, 600, 8'h09);
        tick(); set_pix(1'b0, 0, 0, 0); #1;
        n_compared++; if (drop_count !== 16'd2) begin n_mismatched++; $display("[TB] FAIL range_drop_y: got %0d expected 2", drop_count); end
        tick(); #1;
        n_compared++; if (mem_we !== 1'b0) begin n_mismatched++; $display("[TB] FAIL range_we_dropped_y: got %b expected 0", mem_we); end
        tick();
    endtask

    task automatic test_transparent();
        tick(); set_pix(1'b1, 10, 10, 8'h00);
        tick(); set_pix(1'b0, 0, 0, 0); #1;
        n_compared++; if (mem_we !== 1'b0) begin n_mismatched++; $display("[TB] FAIL transp_we_s1: got %b expected 0", mem_we); end
        tick(); #1;
        n_compared++; if (mem_we !== 1'b0) begin n_mismatched++; $display("[TB] FAIL transp_we_s2: got %b expected 0", mem_we); end
        // The transparent pixel has left S2, so a busy memory must not stall.
        tick(); mem_busy = 1'b1; #1;
        n_compared++; if (pix_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL transp_advanced: got %b expected 1", pix_ready); end
        n_compared++; if (mem_we !== 1'b0) begin n_mismatched++; $display("[TB] FAIL transp_we_busy: got %b expected 0", mem_we); end
        tick(); mem_busy = 1'b0;
    endtask

    task automatic test_stall();
        logic       exp_ready;
        logic       exp_we;
        int         exp_idx;
        for (int c = 0; c < 10; c++) begin
            tick();
            set_pix(c < 3, c + 1, 0, 8'h11 * (c + 1));
            mem_busy = (c >= 3) && (c <= 6);
            #1;
            exp_ready = !((c >= 3) && (c <= 6));
            exp_we    = (c == 2) || (c == 7) || (c == 8);
            exp_idx   = (c == 2) ? 1 : ((c == 8) ? 3 : 2);
            n_compared++; if (pix_ready !== exp_ready) begin n_mismatched++; $display("[TB] FAIL stall_ready c%0d: got %b expected %b", c, pix_ready, exp_ready); end
            n_compared++; if (mem_we !== exp_we) begin n_mismatched++; $display("[TB] FAIL stall_we c%0d: got %b expected %b", c, mem_we, exp_we); end
            if ((c >= 2) && (c <= 8)) begin
                n_compared++; if (mem_addr !== 20'(exp_base + exp_idx)) begin n_mismatched++; $display("[TB] FAIL stall_addr c%0d: got %0d expected %0d", c, mem_addr, exp_base + exp_idx); end
                n_compared++; if (mem_wdata !== 8'(8'h11 * exp_idx)) begin n_mismatched++; $display("[TB] FAIL stall_wdata c%0d: got %h expected %h", c, mem_wdata, 8'(8'h11 * exp_idx)); end
            end
        end
        mem_busy = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 7; c++) begin
            tick();
            set_pix(c < 4, c, 5, 8'h80 + c);
            #1;
            n_compared++; if (pix_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL b2b_ready c%0d: got %b expected 1", c, pix_ready); end
            n_compared++; if (mem_we !== ((c >= 2) && (c <= 5))) begin n_mismatched++; $display("[TB] FAIL b2b_we c%0d: got %b expected %b", c, mem_we, (c >= 2) && (c <= 5)); end
            if ((c >= 2) && (c <= 5)) begin
                n_compared++; if (mem_addr !== 20'(exp_base + 4000 + c - 2)) begin n_mismatched++; $display("[TB] FAIL b2b_addr c%0d: got %0d expected %0d", c, mem_addr, exp_base + 4000 + c - 2); end
                n_compared++; if (mem_wdata !== 8'(8'h80 + c - 2)) begin n_mismatched++; $display("[TB] FAIL b2b_wdata c%0d: got %h expected %h", c, mem_wdata, 8'(8'h80 + c - 2)); end
            end
        end
    endtask

    task automatic test_frame();
        int   old_base;
        logic old_disp;
        old_base = exp_base;
        old_disp = exp_disp;
        model_swap();
        for (int c = 0; c < 10; c++) begin
            tick();
            case (c)
                0:       set_pix(1'b1, 20, 1, 8'h44);
                1:       set_pix(1'b1, 21, 1, 8'h55);
                6:       set_pix(1'b1, 0, 0, 8'h66);
                default: set_pix(1'b0, 0, 0, 0);
            endcase
            // A second rising edge lands in DONE and must be ignored.
            frame_end = (c == 2) || (c >= 4);
            #1;
            n_compared++; if (frame_done !== (c == 4)) begin n_mismatched++; $display("[TB] FAIL frame_done c%0d: got %b expected %b", c, frame_done, c == 4); end
            n_compared++; if (disp_buf !== ((c <= 4) ? old_disp : exp_disp)) begin n_mismatched++; $display("[TB] FAIL frame_disp c%0d: got %b expected %b", c, disp_buf, (c <= 4) ? old_disp : exp_disp); end
            n_compared++; if (mem_we !== ((c == 2) || (c == 3) || (c == 8))) begin n_mismatched++; $display("[TB] FAIL frame_we c%0d: got %b expected %b", c, mem_we, (c == 2) || (c == 3) || (c == 8)); end
            if (c == 2) begin
                n_compared++; if (mem_addr !== 20'(old_base + 820)) begin n_mismatched++; $display("[TB] FAIL frame_addr_a: got %0d expected %0d", mem_addr, old_base + 820); end
            end
            if (c == 3) begin
                n_compared++; if (mem_addr !== 20'(old_base + 821)) begin n_mismatched++; $display("[TB] FAIL frame_addr_b: got %0d expected %0d", mem_addr, old_base + 821); end
                n_compared++; if (mem_wdata !== 8'h55) begin n_mismatched++; $display("[TB] FAIL frame_wdata_b: got %h expected 55", mem_wdata); end
            end
            if (c == 8) begin
                n_compared++; if (mem_addr !== 20'(exp_base)) begin n_mismatched++; $display("[TB] FAIL frame_next_addr: got %0d expected %0d", mem_addr, exp_base); end
                n_compared++; if (mem_wdata !== 8'h66) begin n_mismatched++; $display("[TB] FAIL frame_next_wdata: got %h expected 66", mem_wdata); end
            end
        end
    endtask

    task automatic test_empty_frame();
        logic old_disp;
        old_disp = exp_disp;
        model_swap();
        for (int c = 0; c < 5; c++) begin
            tick();
            frame_end = (c >= 1);
            #1;
            n_compared++; if (frame_done !== (c == 3)) begin n_mismatched++; $display("[TB] FAIL empty_done c%0d: got %b expected %b", c, frame_done, c == 3); end
        end
        n_compared++; if (disp_buf !== exp_disp) begin n_mismatched++; $display("[TB] FAIL empty_disp: got %b expected %b (was %b)", disp_buf, exp_disp, old_disp); end
    endtask

    task automatic test_reset_stall();
        tick(); set_pix(1'b1, 5, 0, 8'h12);
        tick(); set_pix(1'b0, 0, 0, 0);
        tick(); mem_busy = 1'b1; #1;
        n_compared++; if (pix_ready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rs_stalled: got %b expected 0", pix_ready); end
        n_compared++; if (drop_count !== 16'd2) begin n_mismatched++; $display("[TB] FAIL rs_drop_before: got %0d expected 2", drop_count); end
        tick(); aresetn = 1'b0; #1;
        exp_disp = 1'b0;
        exp_base = BACK_WORDS;
        n_compared++; if (mem_we !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rs_we: got %b expected 0", mem_we); end
        n_compared++; if (pix_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL rs_ready: got %b expected 1", pix_ready); end
        n_compared++; if (mem_addr !== 20'd0) begin n_mismatched++; $display("[TB] FAIL rs_addr: got %0d expected 0", mem_addr); end
        n_compared++; if (drop_count !== 16'd0) begin n_mismatched++; $display("[TB] FAIL rs_drop: got %0d expected 0", drop_count); end
        n_compared++; if (disp_buf !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rs_disp: got %b expected 0", disp_buf); end
        tick(); aresetn = 1'b1; mem_busy = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick(); #1;
            n_compared++; if (mem_we !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rs_we_after c%0d: got %b expected 0", c, mem_we); end
            n_compared++; if (frame_done !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rs_done_after c%0d: got %b expected 0", c, frame_done); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_range();
        test_transparent();
        test_stall();
        test_back_to_back();
        test_frame();
        test_empty_frame();
        test_reset_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
